// File: rtl/bcd2_updown_counter_if.sv
`default_nettype none
// ============================================================================
//  Module      : bcd2_updown_counter_if
//  Description : Control/load inputs and BCD digit outputs of the counter.
//  Revision    : 1.0  initial release
// ============================================================================
interface bcd2_updown_counter_if;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] ld_ten;
    logic [3:0] ld_one;
    logic [3:0] ten;
    logic [3:0] one;
    logic       tc;
    logic       ld_err;

    modport master (
        output en, up, load, ld_ten, ld_one,
        input  ten, one, tc, ld_err
    );

    modport slave (
        input  en, up, load, ld_ten, ld_one,
        output ten, one, tc, ld_err
    );
endinterface
`default_nettype wire

// File: rtl/bcd2_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bcd2_updown_counter
//  Description : Two-digit BCD up/down counter (00..TOP) with validated load
//                and terminal-count pulse. Define BCD_SAT_EN for saturation.
//  Revision    : 1.0  initial release
// ============================================================================
module bcd2_updown_counter #(
    parameter int TOP_TEN = 9,
    parameter int TOP_ONE = 9,
    parameter int RST_TEN = 0,
    parameter int RST_ONE = 0
) (
    input  wire logic              clk,
    input  wire logic              rst,
    bcd2_updown_counter_if.slave   bus
);

    localparam logic [3:0] c_TOP_TEN = 4'(TOP_TEN);
    localparam logic [3:0] c_TOP_ONE = 4'(TOP_ONE);
    localparam logic [3:0] c_RST_TEN = 4'(RST_TEN);
    localparam logic [3:0] c_RST_ONE = 4'(RST_ONE);
    localparam logic [7:0] c_TOP_VAL = 8'(10 * TOP_TEN + TOP_ONE);

    logic [3:0] r_ten;
    logic [3:0] r_one;
    logic       r_tc;
    logic       r_ld_err;

    logic [3:0] w_ten_nxt;
    logic [3:0] w_one_nxt;
    logic       w_tc_nxt;
    logic       w_ld_err_nxt;
    logic [7:0] w_ld_val;
    logic       w_ld_valid;
    logic       w_at_top;
    logic       w_at_zero;

    // Binary value of the requested load; digits up to 15 keep this below 256.
    assign w_ld_val   = 8'(bus.ld_ten) * 8'd10 + 8'(bus.ld_one);
    assign w_ld_valid = (bus.ld_ten <= 4'd9) && (bus.ld_one <= 4'd9) &&
                        (w_ld_val <= c_TOP_VAL);
    assign w_at_top   = (r_ten == c_TOP_TEN) && (r_one == c_TOP_ONE);
    assign w_at_zero  = (r_ten == 4'd0) && (r_one == 4'd0);

    always_comb begin
        w_ten_nxt    = r_ten;
        w_one_nxt    = r_one;
        w_tc_nxt     = 1'b0;
        w_ld_err_nxt = 1'b0;
        if (bus.load) begin
            if (w_ld_valid) begin
                w_ten_nxt = bus.ld_ten;
                w_one_nxt = bus.ld_one;
            end else begin
                w_ld_err_nxt = 1'b1;
            end
        end else if (bus.en) begin
            if (bus.up) begin
                if (w_at_top) begin
                    w_tc_nxt = 1'b1;
`ifndef BCD_SAT_EN
                    w_ten_nxt = 4'd0;
                    w_one_nxt = 4'd0;
`endif
                end else if (r_one == 4'd9) begin
                    w_one_nxt = 4'd0;
                    w_ten_nxt = r_ten + 4'd1;
                end else begin
                    w_one_nxt = r_one + 4'd1;
                end
            end else begin
                if (w_at_zero) begin
                    w_tc_nxt = 1'b1;
`ifndef BCD_SAT_EN
                    w_ten_nxt = c_TOP_TEN;
                    w_one_nxt = c_TOP_ONE;
`endif
                end else if (r_one == 4'd0) begin
                    w_one_nxt = 4'd9;
                    w_ten_nxt = r_ten - 4'd1;
                end else begin
                    w_one_nxt = r_one - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ten    <= c_RST_TEN;
            r_one    <= c_RST_ONE;
            r_tc     <= 1'b0;
            r_ld_err <= 1'b0;
        end else begin
            r_ten    <= w_ten_nxt;
            r_one    <= w_one_nxt;
            r_tc     <= w_tc_nxt;
            r_ld_err <= w_ld_err_nxt;
        end
    end

    assign bus.ten    = r_ten;
    assign bus.one    = r_one;
    assign bus.tc     = r_tc;
    assign bus.ld_err = r_ld_err;

endmodule
`default_nettype wire

// File: doc/bcd2_updown_counter.md
Name: bcd2_updown_counter

Overview:
Two-digit BCD up/down counter, 00 to a parameterised TOP value.
- Sits directly upstream of the two-digit BCD-to-binary converter and drives its ONE/TEN inputs.
- Supports parallel load with digit validation and a terminal-count pulse for cascading.
- Typical uses: minutes/hours/setpoint entry whose binary equivalent is produced by the downstream converter.

Parameters:
TOP_TEN, 9, tens digit of the maximum count (0-9)
TOP_ONE, 9, ones digit of the maximum count (0-9); TOP = 10*TOP_TEN + TOP_ONE, must be >= 1
RST_TEN, 0, tens digit after reset; RST value must be <= TOP
RST_ONE, 0, ones digit after reset

Ports:
CLK  input  1  clock, all state changes on rising edge
RST  input  1  synchronous reset, active-high
EN  input  1  count enable, one step per cycle while high
UP  input  1  direction: 1 = increment, 0 = decrement
LOAD  input  1  parallel load request
LD_TEN  input  4  tens digit to load
LD_ONE  input  4  ones digit to load
TEN  output  4  tens digit, registered BCD
ONE  output  4  ones digit, registered BCD
TC  output  1  terminal-count pulse, registered
LD_ERR  output  1  load-rejected pulse, registered

Behaviour:
Interface: one clock; reset is synchronous and active-high (CLK, RST).

Reset and priority:
- RST high at an edge: TEN=RST_TEN, ONE=RST_ONE, TC=0, LD_ERR=0.
- Priority per edge: RST > LOAD > EN. EN is ignored in any cycle where LOAD is high.
- TC and LD_ERR are single-cycle pulses. They default to 0 on every edge unless set by that edge's action.

LOAD:
- Valid when LD_TEN<=9, LD_ONE<=9, and 10*LD_TEN+LD_ONE <= TOP.
- Valid load: TEN/ONE take LD values at the edge; LD_ERR=0; TC=0.
- Invalid load: TEN/ONE hold; LD_ERR=1 for exactly one cycle.
- Latency: 1 clock in both cases.

Count up (EN=1, UP=1):
- At TOP: next value 00, TC=1.
- Else if ONE==9: ONE=0, TEN=TEN+1.
- Else: ONE=ONE+1.

Count down (EN=1, UP=0):
- At 00: next value TOP, TC=1.
- Else if ONE==0: ONE=9, TEN=TEN-1.
- Else: ONE=ONE-1.

Timing and invariants:
- TC rises in the same cycle the wrapped value first appears on TEN/ONE.
- EN=0 and LOAD=0: hold, TC=0, LD_ERR=0.
- UP may change every cycle; each step uses the UP value sampled at that edge.
- Outputs are never non-BCD and never exceed TOP.
- No combinational path from inputs to outputs.
- RST mid-count overrides a simultaneous LOAD/EN.

Optional Feature:
Macro BCD_SAT_EN.
- Defined: saturating mode.
  - Increment at TOP holds TOP; decrement at 00 holds 00.
  - TC=1 for each enabled step blocked at a limit; otherwise TC=0.
  - Loads are unaffected.
- Undefined: wrap-around behaviour as specified above.

Test Plan:
1. Defaults. RST=1 for 2 cycles, then EN=1, UP=1 for 10 cycles -> after reset TEN/ONE=0/0; after 10 steps 1/0, with 0/9->1/0 seen at step 10; TC stays 0.
2. Wrap up. LOAD 9,8, then EN=1, UP=1 for 2 cycles -> 9/9, then 0/0 with TC=1 on that cycle only.
3. Wrap down. From 0/0, EN=1, UP=0 -> 9/9 with TC=1; next step -> 9/8 with TC=0.
4. Load rejection.
   - LOAD with LD_TEN=4, LD_ONE=10 (0xA) while at 3/7 -> holds 3/7, LD_ERR=1 for one cycle.
   - Same cycle with LOAD=1, EN=1 and valid digits 5/2 -> 5/2, no count step.
5. Custom TOP (TOP_TEN=2, TOP_ONE=3).
   - Count up from 2/2 -> 2/3, then 0/0 with TC=1.
   - LOAD 2,4 -> LD_ERR=1.
   - Down from 0/0 -> 2/3.
6. Reset mid-operation and saturation.
   - RST=1 together with LOAD=1 and EN=1 -> RST values, LD_ERR=0.
   - With BCD_SAT_EN defined, at 9/9 with EN=1, UP=1 for 3 cycles -> stays 9/9, TC=1 each cycle.
